// File: rtl/uart_tx.sv
// UART transmitter: one bit period per clk cycle, frame = start, LSB-first data,
// optional parity, one stop bit. tx_out and busy are registered.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  par_bit;

  assign accept  = data_valid && ((state_q == S_IDLE) || (state_q == S_STOP));
  assign par_bit = (^data_q) ^ par_type_q;
  assign cnt_inc = cnt_q + 1'b1;

  // tx_d/busy_d describe the line during the cycle after the edge, so the
  // outputs stay registered while showing the start bit with zero latency.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    tx_d       = 1'b1;
    busy_d     = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      S_DATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_inc;
          tx_d  = data_q[cnt_inc];
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (accept) begin
      state_d    = S_START;
      data_d     = p_data;
      par_en_d   = par_en;
      par_type_d = par_type;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: line bits compared against a frame model
// built from the byte, parity flags and frame rules.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_type;
  logic       tx_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_type   (par_type),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Frame model: start 0, data LSB first, parity from the count of ones, stop 1.
  function automatic int model_frame(input logic [7:0] d, input logic pe, input logic pt,
                                     output logic [10:0] bits);
    int n;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (pe) begin
      bits[n] = logic'(($countones(d) % 2) == 1) ^ pt;
      n++;
    end
    bits[n] = 1'b1;
    return n + 1;
  endfunction

  // Presents a request for one rising edge; data_valid is left high.
  task automatic request(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_type   = pt;
    data_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_type = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state tx_out=%b busy=%b expected tx_out=1 busy=0", tx_out, busy);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle cycle %0d tx_out=%b busy=%b expected tx_out=1 busy=0", i, tx_out, busy);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_idle tx_out=%b busy=%b expected tx_out=1 busy=0", tx_out, busy);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_no_parity;
    logic [7:0]  d;
    logic [10:0] bits;
    int          len;
    for (int k = 0; k < 4; k++) begin
      d   = (k == 0) ? 8'hA5 : 8'($urandom);
      len = model_frame(d, 1'b0, 1'b0, bits);
      request(d, 1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if (i == 0) data_valid = 1'b0;
        checks++;
        if (tx_out !== bits[i] || busy !== 1'b1) begin
          errors++;
          $display("FAIL no_parity d=%h bit %0d tx_out=%b busy=%b expected tx_out=%b busy=1",
                   d, i, tx_out, busy, bits[i]);
        end
      end
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_parity_idle d=%h tx_out=%b busy=%b expected tx_out=1 busy=0", d, tx_out, busy);
      end
    end
  endtask

  task automatic test_parity;
    logic [7:0]  dtab [3] = '{8'hA5, 8'h07, 8'h07};
    logic        ptab [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0]  d;
    logic        pt;
    logic [10:0] bits;
    int          len;
    for (int k = 0; k < 7; k++) begin
      d   = (k < 3) ? dtab[k] : 8'($urandom);
      pt  = (k < 3) ? ptab[k] : 1'($urandom);
      len = model_frame(d, 1'b1, pt, bits);
      request(d, 1'b1, pt);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if (i == 0) data_valid = 1'b0;
        checks++;
        if (tx_out !== bits[i] || busy !== 1'b1) begin
          errors++;
          $display("FAIL parity d=%h type=%b bit %0d tx_out=%b busy=%b expected tx_out=%b busy=1",
                   d, pt, i, tx_out, busy, bits[i]);
        end
      end
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL parity_idle d=%h tx_out=%b busy=%b expected tx_out=1 busy=0", d, tx_out, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  d1, d2;
    logic        pe1, pt1, pe2, pt2;
    logic [10:0] b1, b2;
    int          l1, l2;
    logic        exp_bit;
    for (int k = 0; k < 3; k++) begin
      d1  = (k == 0) ? 8'h55 : 8'($urandom);
      d2  = (k == 0) ? 8'hFF : 8'($urandom);
      pe1 = (k == 0) ? 1'b0 : 1'($urandom);
      pt1 = 1'($urandom);
      pe2 = (k == 0) ? 1'b0 : 1'($urandom);
      pt2 = 1'($urandom);
      l1  = model_frame(d1, pe1, pt1, b1);
      l2  = model_frame(d2, pe2, pt2, b2);
      request(d1, pe1, pt1);
      for (int i = 0; i < l1 + l2; i++) begin
        @(negedge clk);
        if (i == 0) begin
          p_data = d2; par_en = pe2; par_type = pt2;
        end
        if (i == l1) data_valid = 1'b0;
        exp_bit = (i < l1) ? b1[i] : b2[i-l1];
        checks++;
        if (tx_out !== exp_bit || busy !== 1'b1) begin
          errors++;
          $display("FAIL back_to_back %h/%h bit %0d tx_out=%b busy=%b expected tx_out=%b busy=1",
                   d1, d2, i, tx_out, busy, exp_bit);
        end
      end
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back_idle tx_out=%b busy=%b expected tx_out=1 busy=0", tx_out, busy);
      end
    end
  endtask

  task automatic test_ignore_midframe;
    logic [7:0]  d;
    logic        pe, pt;
    logic [10:0] bits;
    int          len;
    for (int k = 0; k < 3; k++) begin
      d   = 8'($urandom_range(1, 255));
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      len = model_frame(d, pe, pt, bits);
      request(d, pe, pt);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if (i == 0) data_valid = 1'b0;
        if (i == 3) begin
          p_data = 8'h00; par_en = ~pe; par_type = ~pt; data_valid = 1'b1;
        end
        if (i == 4) data_valid = 1'b0;
        checks++;
        if (tx_out !== bits[i] || busy !== 1'b1) begin
          errors++;
          $display("FAIL ignore_midframe d=%h bit %0d tx_out=%b busy=%b expected tx_out=%b busy=1",
                   d, i, tx_out, busy, bits[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL ignore_midframe_idle cycle %0d tx_out=%b busy=%b expected tx_out=1 busy=0",
                   i, tx_out, busy);
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0]  d;
    logic        pt;
    logic [10:0] bits;
    int          len;
    d   = 8'hF0;
    len = model_frame(d, 1'b0, 1'b0, bits);
    request(d, 1'b0, 1'b0);
    // Index 4 on the line is the 4th data bit.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
      checks++;
      if (tx_out !== bits[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL pre_abort bit %0d tx_out=%b busy=%b expected tx_out=%b busy=1",
                 i, tx_out, busy, bits[i]);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_abort tx_out=%b busy=%b expected tx_out=1 busy=0", tx_out, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_abort_idle cycle %0d tx_out=%b busy=%b expected tx_out=1 busy=0",
                 i, tx_out, busy);
      end
    end
    d   = 8'($urandom);
    pt  = 1'($urandom);
    len = model_frame(d, 1'b1, pt, bits);
    request(d, 1'b1, pt);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
      checks++;
      if (tx_out !== bits[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL post_abort_frame d=%h bit %0d tx_out=%b busy=%b expected tx_out=%b busy=1",
                 d, i, tx_out, busy, bits[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_abort_end tx_out=%b busy=%b expected tx_out=1 busy=0", tx_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
